// File: rtl/qosc_pkg.sv
// Shared definitions for the quadrature oscillator configuration path:
// opcodes, register indices, loader FSM states and operand defaults.
package qosc_pkg;

   localparam logic [3:0] OP_WRITE  = 4'h1;
   localparam logic [3:0] OP_COMMIT = 4'h2;
   localparam logic [3:0] OP_RUN    = 4'h3;
   localparam logic [3:0] OP_CLRERR = 4'h4;

   localparam logic [2:0] IDX_RE      = 3'd0;
   localparam logic [2:0] IDX_IM      = 3'd1;
   localparam logic [2:0] IDX_PWR     = 3'd2;
   localparam logic [2:0] IDX_INIT_RE = 3'd3;
   localparam logic [2:0] IDX_INIT_IM = 3'd4;
   localparam logic [2:0] IDX_DIV     = 3'd5;

   localparam logic [15:0] QOSC_DEF_RE      = 16'h7FFF;
   localparam logic [15:0] QOSC_DEF_IM      = 16'h0000;
   localparam logic [15:0] QOSC_DEF_PWR     = 16'h4000;
   localparam logic [15:0] QOSC_DEF_INIT_RE = 16'h4000;
   localparam logic [15:0] QOSC_DEF_INIT_IM = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HI     = 2'd1,
      ST_LO     = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   // One complete operand set; used for both the shadow and the active copy.
   typedef struct packed {
      logic [15:0] re;
      logic [15:0] im;
      logic [15:0] pwr;
      logic [15:0] init_re;
      logic [15:0] init_im;
      logic [15:0] div;
   } regs_t;

   // Returns r with the field selected by idx replaced; indices 6/7 leave r untouched.
   function automatic regs_t regs_write(input regs_t r, input logic [2:0] idx,
                                        input logic [15:0] val);
      regs_t n;
      n = r;
      case (idx)
         IDX_RE:      n.re      = val;
         IDX_IM:      n.im      = val;
         IDX_PWR:     n.pwr     = val;
         IDX_INIT_RE: n.init_re = val;
         IDX_INIT_IM: n.init_im = val;
         IDX_DIV:     n.div     = val;
         default:     n         = r;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/qosc_step_prescaler.sv
// Programmable step strobe: fires when the free-running count reaches div,
// then wraps, giving a period of div+1 cycles while run is high.
module qosc_step_prescaler (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        clear,
   input  logic [15:0] div,
   output logic        step_en
);

   logic [15:0] cnt;
   logic        at_div;

   always_comb begin
      // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
      at_div = 1'b0;
      if (cnt == div) begin
         at_div = 1'b1;
      end
   end

   // Decoded from registered state only; clear suppresses the strobe during the load cycle.
   assign step_en = run && !clear && at_div;

   // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run) begin
         if (at_div) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 16'd1;
         end
      end
   end

endmodule

// File: rtl/qosc_config_loader.sv
// Byte-serial configuration front end for the quadrature oscillator: shadow/active
// operand registers, commit-driven load pulse and the step strobe prescaler.
module qosc_config_loader
   import qosc_pkg::*;
#(
   parameter logic [15:0] DEF_RE      = QOSC_DEF_RE,
   parameter logic [15:0] DEF_IM      = QOSC_DEF_IM,
   parameter logic [15:0] DEF_PWR     = QOSC_DEF_PWR,
   parameter logic [15:0] DEF_INIT_RE = QOSC_DEF_INIT_RE,
   parameter logic [15:0] DEF_INIT_IM = QOSC_DEF_INIT_IM
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_valid,
   input  logic [7:0]         wr_data,
   output logic               wr_ready,
   output logic signed [15:0] re_coeff,
   output logic signed [15:0] im_coeff,
   output logic signed [15:0] power,
   output logic signed [15:0] accu_re_init,
   output logic signed [15:0] accu_im_init,
   output logic               load,
   output logic               step_en,
   output logic               run,
   output logic               err
);

   localparam regs_t DEF_REGS = '{
      re:      DEF_RE,
      im:      DEF_IM,
      pwr:     DEF_PWR,
      init_re: DEF_INIT_RE,
      init_im: DEF_INIT_IM,
      div:     16'h0000
   };

   state_t      state;
   regs_t       shadow;
   regs_t       active;
   logic [7:0]  hi_byte;
   logic [2:0]  wr_idx;
   logic        xfer;
   logic [3:0]  cmd_op;
   logic [2:0]  cmd_idx;

   assign wr_ready = (state != ST_COMMIT);
   assign xfer     = wr_valid && wr_ready;
   assign cmd_op   = wr_data[7:4];
   assign cmd_idx  = wr_data[2:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         shadow <= DEF_REGS;
         active <= DEF_REGS;
         load   <= 1'b0;
         run    <= 1'b0;
         err    <= 1'b0;
      end else begin
         load <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  case (cmd_op)
                     OP_WRITE: begin
                        state <= ST_HI;
                        // Out-of-range targets still swallow their two data bytes.
                        if (cmd_idx > IDX_DIV) begin
                           err <= 1'b1;
                        end
                     end
                     OP_COMMIT: begin
                        // Load and the new operands appear together, while wr_ready is low.
                        state  <= ST_COMMIT;
                        active <= shadow;
                        load   <= 1'b1;
                     end
                     OP_RUN:    run <= cmd_idx[0];
                     OP_CLRERR: err <= 1'b0;
                     default:   err <= 1'b1;
                  endcase
               end
            end
            ST_HI: begin
               if (xfer) begin
                  state <= ST_LO;
               end
            end
            ST_LO: begin
               if (xfer) begin
                  state  <= ST_IDLE;
                  shadow <= regs_write(shadow, wr_idx, {hi_byte, wr_data});
               end
            end
            ST_COMMIT: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: data-path holding registers are deliberately not reset; the FSM reset makes their contents irrelevant.
   always_ff @(posedge clk) begin
      if (xfer && (state == ST_IDLE) && (cmd_op == OP_WRITE)) begin
         wr_idx <= cmd_idx;
      end
      if (xfer && (state == ST_HI)) begin
         hi_byte <= wr_data;
      end
   end

   assign re_coeff     = active.re;
   assign im_coeff     = active.im;
   assign power        = active.pwr;
   assign accu_re_init = active.init_re;
   assign accu_im_init = active.init_im;

   qosc_step_prescaler u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .clear   (load),
      .div     (active.div),
      .step_en (step_en)
   );

endmodule

// File: tb/tb_qosc_config_loader.sv
// Self-checking bench for qosc_config_loader: directed scenarios followed by
// random byte traffic, all compared against a byte-level behavioural model.
module tb_qosc_config_loader;

   logic               clk = 1'b0;
   logic               rst;
   logic               wr_valid;
   logic [7:0]         wr_data;
   logic               wr_ready;
   logic signed [15:0] re_coeff;
   logic signed [15:0] im_coeff;
   logic signed [15:0] power;
   logic signed [15:0] accu_re_init;
   logic signed [15:0] accu_im_init;
   logic               load;
   logic               step_en;
   logic               run;
   logic               err;

   always #5 clk = ~clk;

   qosc_config_loader dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .re_coeff     (re_coeff),
      .im_coeff     (im_coeff),
      .power        (power),
      .accu_re_init (accu_re_init),
      .accu_im_init (accu_im_init),
      .load         (load),
      .step_en      (step_en),
      .run          (run),
      .err          (err)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: operand arrays (0 re,1 im,2 pwr,3 init_re,4 init_im,5 div),
   // the byte position inside the current command, and running cycles since last load.
   logic [15:0] m_sh [6];
   logic [15:0] m_ac [6];
   logic        m_run, m_err, m_load;
   int          m_phase;
   int          m_idx;
   logic [7:0]  m_hi;
   int          m_rc;
   logic        tick_acc;

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_sh   = '{16'h7FFF, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 16'h0000};
      m_ac   = m_sh;
      m_run  = 1'b0;
      m_err  = 1'b0;
      m_load = 1'b0;
      m_phase = 0;
      m_idx  = 0;
      m_rc   = 0;
   endtask

   task automatic model_edge(input logic acc, input logic [7:0] b);
      logic prev_load, prev_run;
      int   op;
      prev_load = m_load;
      prev_run  = m_run;
      m_load    = 1'b0;
      if (prev_load) m_rc = 0;
      else if (prev_run) m_rc++;
      if (acc) begin
         if (m_phase == 0) begin
            op = int'(b) / 16;
            if (op == 1) begin
               m_idx = int'(b) % 8;
               m_phase = 1;
               if (m_idx > 5) m_err = 1'b1;
            end else if (op == 2) begin
               m_ac   = m_sh;
               m_load = 1'b1;
            end else if (op == 3) begin
               m_run = b[0];
            end else if (op == 4) begin
               m_err = 1'b0;
            end else begin
               m_err = 1'b1;
            end
         end else if (m_phase == 1) begin
            m_hi = b;
            m_phase = 2;
         end else begin
            if (m_idx <= 5) m_sh[m_idx] = {m_hi, b};
            m_phase = 0;
         end
      end
   endtask

   task automatic check_outputs();
      int   dv;
      logic exp_step;
      dv = int'(m_ac[5]);
      exp_step = m_run && !m_load && ((m_rc % (dv + 1)) == dv);
      chk("step_en", 80'(step_en), 80'(exp_step));
      chk("load", 80'(load), 80'(m_load));
      chk("run", 80'(run), 80'(m_run));
      chk("err", 80'(err), 80'(m_err));
      chk("operands", {re_coeff, im_coeff, power, accu_re_init, accu_im_init},
          {m_ac[0], m_ac[1], m_ac[2], m_ac[3], m_ac[4]});
   endtask

   // One clock: check ready before the edge, advance the model, check outputs after it.
   task automatic tick();
      logic       acc, r;
      logic [7:0] b;
      chk("wr_ready", 80'(wr_ready), 80'(!m_load));
      acc = wr_valid && !m_load && !rst;
      b   = wr_data;
      r   = rst;
      @(posedge clk);
      #1;
      if (r) model_reset();
      else model_edge(acc, b);
      check_outputs();
      tick_acc = acc;
   endtask

   // Leaves wr_valid high so back-to-back bytes stay continuous.
   task automatic send_byte(input logic [7:0] b);
      int k;
      wr_valid = 1'b1;
      wr_data  = b;
      k = 0;
      do begin
         tick();
         k++;
      end while (!tick_acc && k < 8);
      n_cmp++;
      assert (tick_acc)
      else begin
         n_fail++;
         $error("FAIL accept_timeout observed=%0d expected=accepted byte=%0h", k, b);
      end
   endtask

   task automatic idle(input int n);
      wr_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_reset();
      wr_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int          k;
      logic [2:0]  ix;
      logic [7:0]  b;

      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      tick_acc = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_outputs();
      idle(3);

      // Shadow write is invisible until commit.
      send_byte(8'h10); send_byte(8'h12); send_byte(8'h34);
      idle(2);
      send_byte(8'h20);
      idle(2);

      // Divider 2, commit, run: strobe every third cycle; stop and resume.
      send_byte(8'h15); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h20); send_byte(8'h31);
      idle(12);
      send_byte(8'h30);
      idle(5);
      send_byte(8'h31);
      idle(7);

      // Divider 0 strobes every cycle.
      send_byte(8'h15); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h20);
      idle(4);

      // Out-of-range write index sets err; CLRERR clears it; bad opcode sets it.
      send_byte(8'h16); send_byte(8'hAA); send_byte(8'hBB);
      idle(1);
      send_byte(8'h40);
      idle(1);
      send_byte(8'h90);
      send_byte(8'h40);
      idle(1);

      // Reset mid-write abandons the word; commit then loads defaults.
      send_byte(8'h11); send_byte(8'h55);
      pulse_reset();
      send_byte(8'h20);
      idle(2);

      // Byte held valid across the commit cycle is taken exactly once afterwards.
      send_byte(8'h20);
      send_byte(8'h31);
      idle(6);
      send_byte(8'h30);

      // Random traffic.
      for (int n = 0; n < 150; n++) begin
         k = int'($urandom_range(0, 20));
         if (k <= 7) begin
            ix = 3'($urandom_range(0, 7));
            b  = {4'h1, 1'($urandom_range(0, 1)), ix};
            send_byte(b);
            if (ix == 3'd5) begin
               send_byte(8'h00);
               send_byte(8'($urandom_range(0, 4)));
            end else begin
               send_byte(8'($urandom));
               send_byte(8'($urandom));
            end
         end else if (k <= 10) begin
            send_byte(8'h20);
         end else if (k <= 13) begin
            send_byte({4'h3, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))});
         end else if (k == 14) begin
            send_byte({4'h4, 4'($urandom)});
         end else if (k == 15) begin
            send_byte(8'($urandom));
         end else if (k == 16) begin
            pulse_reset();
         end else begin
            idle(int'($urandom_range(0, 8)));
         end
      end
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
